// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the frame reader: FSM encoding, RGB565 field
// positions and the luma coefficients used by the optional grayscale path.
package frame_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_HI = 3'd1,
    S_RD_LO = 3'd2,
    S_CAP   = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Luma weights scaled by 256; they sum to exactly 256 so white maps to 255.
  localparam logic [15:0] Y_COEF_R = 16'd77;
  localparam logic [15:0] Y_COEF_G = 16'd150;
  localparam logic [15:0] Y_COEF_B = 16'd29;

endpackage

// File: rtl/frame_reader_rgb565_to_gray.sv
// Combinational RGB565 -> luma converter, result re-packed as a gray RGB565 word.
// Only instantiated by frame_reader when GRAYSCALE_EN is defined.
module rgb565_to_gray
  import frame_reader_pkg::*;
(
  input  logic [15:0] rgb,
  output logic [15:0] gray
);

  logic [7:0]  r8, g8, b8, y;
  logic [15:0] y16;

  // Replicate the top bits so full-scale fields expand to exactly 8'hFF.
  assign r8 = {rgb[R_MSB:R_LSB], rgb[R_MSB -: 3]};
  assign g8 = {rgb[G_MSB:G_LSB], rgb[G_MSB -: 2]};
  assign b8 = {rgb[B_MSB:B_LSB], rgb[B_MSB -: 3]};

  assign y16 = ({8'd0, r8} * Y_COEF_R) + ({8'd0, g8} * Y_COEF_G) + ({8'd0, b8} * Y_COEF_B);
  assign y   = 8'(y16 >> 8);

  assign gray = {y[7:3], y[7:2], y[7:3]};

endmodule

// File: rtl/frame_reader.sv
// Drains a captured frame from the byte-wide frame buffer as RGB565 pixels with
// sof/eol/eof markers. Define GRAYSCALE_EN to emit luma-converted pixels instead.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int H_RES     = 160,
  parameter int V_RES     = 120,
  parameter int BUFF_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_read,
  input  logic                 frame_captured,
  output logic [BUFF_BITS-1:0] buf_addr,
  output logic                 buf_rd,
  input  logic [7:0]           buf_rdata,
  output logic [15:0]          pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic                 pix_eof,
  output logic                 read_done
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES + 1) : 1;
  localparam int KW    = BUFF_BITS - 1;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [KW-1:0]    k;
  logic [7:0]       hi_reg;
  logic [15:0]      cap_word, cap_pix;
  logic             last_col, last_row;

  assign cap_word = {hi_reg, buf_rdata};
  assign last_col = (col == COL_W'(H_RES - 1));
  assign last_row = (row == ROW_W'(V_RES - 1));

`ifdef GRAYSCALE_EN
  rgb565_to_gray u_gray (
    .rgb  (cap_word),
    .gray (cap_pix)
  );
`else
  assign cap_pix = cap_word;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      k         <= '0;
      hi_reg    <= '0;
      buf_addr  <= '0;
      buf_rd    <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      read_done <= 1'b0;
    end else if (state != S_IDLE && !start_read) begin
      // Abort: any pending pixel is dropped and the next trigger starts over.
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      k         <= '0;
      buf_rd    <= 1'b0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
      read_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_read && frame_captured) begin
            state    <= S_RD_HI;
            col      <= '0;
            row      <= '0;
            k        <= '0;
            buf_rd   <= 1'b1;
            buf_addr <= '0;
          end
        end
        S_RD_HI: begin
          state    <= S_RD_LO;
          buf_rd   <= 1'b1;
          buf_addr <= {k, 1'b1};
        end
        S_RD_LO: begin
          // High byte from the RD_HI read is on buf_rdata now.
          hi_reg <= buf_rdata;
          buf_rd <= 1'b0;
          state  <= S_CAP;
        end
        S_CAP: begin
          pix_data  <= cap_pix;
          pix_valid <= 1'b1;
          pix_sof   <= (col == '0) && (row == '0);
          pix_eol   <= last_col;
          pix_eof   <= last_col && last_row;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            k         <= k + KW'(1);
            if (last_col) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if (last_col && last_row) begin
              state     <= S_DONE;
              read_done <= 1'b1;
            end else begin
              state    <= S_RD_HI;
              buf_rd   <= 1'b1;
              buf_addr <= {k + KW'(1), 1'b0};
            end
          end
        end
        S_DONE: begin
          read_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Randomized bench for frame_reader: a frame-level model predicts the pixel
// stream, read addresses and read_done from the buffer contents.
module tb_frame_reader;

  localparam int H_RES  = 160;
  localparam int V_RES  = 120;
  localparam int BB     = 16;
  localparam int NPIX   = H_RES * V_RES;
  localparam int NBYTES = 2 * NPIX;

  logic          clk = 1'b0;
  logic          rst, start_read, frame_captured, pix_ready;
  logic [BB-1:0] buf_addr;
  logic          buf_rd;
  logic [7:0]    buf_rdata;
  logic [15:0]   pix_data;
  logic          pix_valid, pix_sof, pix_eol, pix_eof, read_done;

  frame_reader #(.H_RES(H_RES), .V_RES(V_RES), .BUFF_BITS(BB)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_read     (start_read),
    .frame_captured (frame_captured),
    .buf_addr       (buf_addr),
    .buf_rd         (buf_rd),
    .buf_rdata      (buf_rdata),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_sof        (pix_sof),
    .pix_eol        (pix_eol),
    .pix_eof        (pix_eof),
    .read_done      (read_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:NBYTES-1];

  always @(posedge clk) begin
    if (buf_rd) buf_rdata <= (int'(buf_addr) < NBYTES) ? mem[buf_addr] : 8'hxx;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected pixel k straight from the buffer contents.
  function automatic logic [15:0] exp_pix(input int k);
    int raw, r, g, b, y;
    raw = {mem[2*k], mem[2*k+1]};
`ifdef GRAYSCALE_EN
    r = ((raw >> 11) & 31) * 8 + (((raw >> 11) & 31) / 4);
    g = ((raw >> 5) & 63) * 4 + (((raw >> 5) & 63) / 16);
    b = (raw & 31) * 8 + ((raw & 31) / 4);
    y = (77 * r + 150 * g + 29 * b) / 256;
    return 16'(((y / 8) * 2048) + ((y / 4) * 32) + (y / 8));
`else
    r = 0; g = 0; b = 0; y = 0;
    return 16'(raw);
`endif
  endfunction

  // Model state: pixels accepted and reads issued in the current frame read.
  int   k_exp = 0, rd_exp = 0, eol_cnt = 0, eof_cnt = 0, max_addr = 0;
  bit   done_flag = 0, chk_on = 0;
  int   prev_flush = 2;
  bit   prev_hold = 0;
  logic [18:0] prev_out;

  always @(negedge clk) begin : cmp
    bit acc;
    if (chk_on) begin
      if (prev_flush == 2)
        check("reset_outputs", {buf_addr, buf_rd, pix_data, pix_valid, pix_sof, pix_eol, pix_eof, read_done}, '0);
      else if (prev_flush == 1)
        check("abort_idle", {pix_valid, buf_rd}, 2'b00);
      check("read_done", read_done, done_flag);
      if (buf_rd) begin
        check("buf_addr", {buf_addr, pix_valid}, {BB'(rd_exp), 1'b0});
        if (int'(buf_addr) > max_addr) max_addr = int'(buf_addr);
        rd_exp++;
      end
      if (prev_hold && pix_valid)
        check("stall_stable", {pix_data, pix_sof, pix_eol, pix_eof}, prev_out);
      acc = pix_valid && pix_ready && start_read && !rst;
      if (acc) begin
        check("pix_data", pix_data, exp_pix(k_exp));
        check("markers", {pix_sof, pix_eol, pix_eof},
              {k_exp == 0, (k_exp % H_RES) == H_RES - 1, k_exp == NPIX - 1});
        if (pix_eol) eol_cnt++;
        if (pix_eof) eof_cnt++;
        k_exp++;
        if (k_exp == NPIX) done_flag = 1;
      end
      prev_hold = pix_valid && !acc;
      prev_out  = {pix_data, pix_sof, pix_eol, pix_eof};
      if (rst || !start_read) begin
        k_exp = 0; rd_exp = 0; done_flag = 0;
        eol_cnt = 0; eof_cnt = 0; max_addr = 0;
        prev_hold = 0;
        prev_flush = rst ? 2 : 1;
      end else begin
        prev_flush = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; start_read = 1'b0; frame_captured = 1'b0; pix_ready = 1'b0;
    for (int i = 0; i < NBYTES; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hF8; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'hFF;
    tick();
    chk_on = 1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // First pixel: latency and literal value.
    start_read = 1'b1; frame_captured = 1'b1; pix_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!pix_valid && n < 20);
    check("first_latency", n, 4);
`ifdef GRAYSCALE_EN
    check("first_pix_lit", {pix_data, pix_sof}, {16'h4A69, 1'b1});
`else
    check("first_pix_lit", {pix_data, pix_sof}, {16'hF800, 1'b1});
`endif
    tick();
    n = 0;
    while (!pix_valid && n < 20) begin tick(); n++; end
    check("second_pix_lit", pix_data, 16'hFFFF);

    // Random back-pressure up to pixel 500, then abort while a pixel is held.
    n = 0;
    while (k_exp < 500 && n < 10000) begin
      pix_ready = ($urandom_range(0, 9) < 7);
      tick(); n++;
    end
    pix_ready = 1'b0;
    while (!pix_valid && n < 10000) begin tick(); n++; end
    check("t4_reach", n < 10000, 1'b1);
    start_read = 1'b0;
    tick();
    check("abort_valid", pix_valid, 1'b0);
    frame_captured = 1'b0;
    tick(); tick();

    // Retrigger, then reset while a pixel is waiting in OUT.
    start_read = 1'b1; frame_captured = 1'b1; pix_ready = 1'b1;
    n = 0;
    while (k_exp < 37 && n < 2000) begin
      pix_ready = ($urandom_range(0, 3) != 0);
      tick(); n++;
    end
    pix_ready = 1'b0;
    while (!pix_valid && n < 2000) begin tick(); n++; end
    check("t5_reach", n < 2000, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pix_ready = 1'b1;
    n = 0;
    while (k_exp < 3 && n < 100) begin tick(); n++; end
    check("rst_restart", k_exp, 3);

    // Full frame with one 10-cycle stall mid-line; frame_captured drops early.
    start_read = 1'b0;
    tick(); tick();
    start_read = 1'b1;
    tick(); tick();
    frame_captured = 1'b0;
    n = 0;
    while (k_exp < 1037 && n < 10000) begin tick(); n++; end
    pix_ready = 1'b0;
    while (!pix_valid && n < 10000) begin tick(); n++; end
    for (int i = 0; i < 10; i++) tick();
    pix_ready = 1'b1;
    n = 0;
    while (!read_done && n < 90000) begin tick(); n++; end
    check("frame_timeout", n < 90000, 1'b1);
    check("frame_accepts", k_exp, NPIX);
    check("eol_count", eol_cnt, V_RES);
    check("eof_count", eof_cnt, 1);
    check("max_addr", max_addr, NBYTES - 1);
    tick(); tick();
    check("done_held", read_done, 1'b1);
    start_read = 1'b0;
    tick();
    check("done_cleared", read_done, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
